// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory among the MEM stage, a debug port and a dump sequencer.
// Fixed priority pipe > dbg > dump; read data is routed back to its owner by a registered tag.
module dmem_port_arbiter #(
  parameter int SIZE   = 32,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_rd,
  input  logic              pipe_wr,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [SIZE-1:0]   pipe_wdata,
  output logic [SIZE-1:0]   pipe_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [SIZE-1:0]   dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [SIZE-1:0]   dbg_rdata,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [SIZE-1:0]   dump_data,
  output logic              dump_done,
  output logic [1:0]        dump_state,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  input  logic [SIZE-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dump_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_PIPE, TAG_DBG, TAG_DUMP} tag_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dump_state_t       state, state_d;
  tag_t              tag, tag_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W-1:0] issue_addr;
  logic              done_d;
  logic              pipe_acc, dbg_oor, dbg_oor_q, dump_win;

  assign pipe_acc   = pipe_rd | pipe_wr;
  assign dbg_oor    = 32'(dbg_addr) >= 32'(DEPTH);
  assign dbg_gnt    = dbg_req & ~pipe_acc;
  assign dump_win   = (state == RUN) & ~pipe_acc & ~dbg_req;
  assign dump_busy  = (state != IDLE);
  assign dump_state = state;

  // Port mux. Out-of-range debug accesses are granted but never touch the array.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    if (pipe_acc) begin
      mem_en    = 1'b1;
      mem_we    = pipe_wr;
      mem_addr  = pipe_addr;
      mem_wdata = pipe_wdata;
      tag_d     = pipe_wr ? TAG_NONE : TAG_PIPE;
    end else if (dbg_req) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_en    = ~dbg_oor;
      mem_we    = dbg_we & ~dbg_oor;
      tag_d     = dbg_we ? TAG_NONE : TAG_DBG;
    end else if (state == RUN) begin
      mem_en    = 1'b1;
      mem_addr  = ptr;
      tag_d     = TAG_DUMP;
    end
  end

  // Read-return routing: mem_rdata belongs to whoever issued last cycle's read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag        <= TAG_NONE;
      dbg_oor_q  <= 1'b0;
      issue_addr <= '0;
      pipe_rdata <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      tag        <= tag_d;
      dbg_oor_q  <= dbg_oor;
      dbg_rvalid <= (tag == TAG_DBG);
      dump_valid <= (tag == TAG_DUMP);
      if (dump_win) issue_addr <= ptr;
      case (tag)
        TAG_PIPE: pipe_rdata <= mem_rdata;
        TAG_DBG:  dbg_rdata  <= dbg_oor_q ? '0 : mem_rdata;
        TAG_DUMP: begin
          dump_data <= mem_rdata;
          dump_addr <= issue_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      dump_done <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      dump_done <= done_d;
    end
  end

  // ptr only advances on a won slot, so stalls never skip or repeat an address.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    done_d  = 1'b0;
    case (state)
      IDLE: if (dump_start) begin
        state_d = RUN;
        ptr_d   = '0;
      end
      RUN: if (dump_win) begin
        ptr_d = ptr + ADDR_W'(1);
        if (ptr == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: if (dump_valid && dump_addr == LAST_ADDR) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
